// File: rtl/ex_div_unit.sv
// ex_div_unit: multi-cycle restoring divider for DIV/DIVU in the EX stage.
// Holds EX via stallreq_for_ex while iterating, then holds the finished
// quotient (LO) / remainder (HI) until the stall bus lets EX advance.
//
// Handshake: div_start acts as "valid" and stays high while the instruction
// sits in EX. Completion is result_valid=1 (state DONE). The result is
// consumed on the first DONE cycle where stall[3]==0, i.e. the EX/MEM
// register accepts it. DONE ignores div_start, so a held request never
// retriggers the division.
module ex_div_unit #(
  parameter int DATA_W  = 32,
  parameter int STALL_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               div_start,
  input  logic               div_signed,
  input  logic [DATA_W-1:0]  dividend,
  input  logic [DATA_W-1:0]  divisor,
  output logic               stallreq_for_ex,
  output logic               result_valid,
  output logic [DATA_W-1:0]  quotient,
  output logic [DATA_W-1:0]  remainder,
  output logic [1:0]         dbg_state
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] ONE_W    = DATA_W'(1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W:0]     rem_q, rem_d;       // one extra bit so the compare cannot overflow
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dvsr_q, dvsr_d;
  logic                q_neg_q, q_neg_d;
  logic                r_neg_q, r_neg_d;
  logic [DATA_W-1:0]   quotient_q, quotient_d;
  logic [DATA_W-1:0]   remainder_q, remainder_d;

  logic [DATA_W-1:0]   dvd_abs, dvs_abs;
  logic [DATA_W:0]     rem_shift, rem_step;
  logic [DATA_W-1:0]   quo_shift, quo_step;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  // Next-state, one restoring step per CALC cycle, and stall request.
  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    rem_d           = rem_q;
    quo_d           = quo_q;
    dvsr_d          = dvsr_q;
    q_neg_d         = q_neg_q;
    r_neg_d         = r_neg_q;
    quotient_d      = quotient_q;
    remainder_d     = remainder_q;
    stallreq_for_ex = 1'b0;

    // Operand magnitudes; unsigned mode passes operands through untouched.
    dvd_abs = (div_signed && dividend[DATA_W-1]) ? (~dividend + ONE_W) : dividend;
    dvs_abs = (div_signed && divisor[DATA_W-1])  ? (~divisor + ONE_W)  : divisor;

    // Shift {rem, quo} left one bit, then subtract the divisor if it fits.
    rem_shift = {rem_q[DATA_W-1:0], quo_q[DATA_W-1]};
    quo_shift = {quo_q[DATA_W-2:0], 1'b0};
    if (rem_shift >= {1'b0, dvsr_q}) begin
      rem_step = rem_shift - {1'b0, dvsr_q};
      quo_step = quo_shift | ONE_W;
    end else begin
      rem_step = rem_shift;
      quo_step = quo_shift;
    end

    unique case (state_q)
      IDLE: begin
        stallreq_for_ex = div_start;
        if (div_start) begin
          rem_d   = '0;
          quo_d   = dvd_abs;
          dvsr_d  = dvs_abs;
          count_d = '0;
          q_neg_d = div_signed & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
          r_neg_d = div_signed & dividend[DATA_W-1];
          if (divisor == '0) begin
            // Divide by zero: all-ones quotient, dividend returned unchanged.
            quotient_d  = '1;
            remainder_d = dividend;
            state_d     = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        stallreq_for_ex = 1'b1;
        rem_d   = rem_step;
        quo_d   = quo_step;
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST_CNT) begin
          quotient_d  = q_neg_q ? (~quo_step + ONE_W) : quo_step;
          remainder_d = r_neg_q ? (~rem_step[DATA_W-1:0] + ONE_W) : rem_step[DATA_W-1:0];
          count_d     = '0;
          state_d     = DONE;
        end
      end
      DONE: begin
        // EX/MEM accepting the instruction releases the result.
        if (!stall[3]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign result_valid = (state_q == DONE);
  assign quotient     = quotient_q;
  assign remainder    = remainder_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// tb_ex_div_unit: scoreboard bench for ex_div_unit.
module tb_ex_div_unit;

  localparam int DATA_W  = 32;
  localparam int STALL_W = 6;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic               clk;
  logic               rst;
  logic [STALL_W-1:0] stall;
  logic               div_start;
  logic               div_signed;
  logic [DATA_W-1:0]  dividend;
  logic [DATA_W-1:0]  divisor;
  logic               stallreq_for_ex;
  logic               result_valid;
  logic [DATA_W-1:0]  quotient;
  logic [DATA_W-1:0]  remainder;
  logic [1:0]         dbg_state;

  logic               hold_stall;
  logic               rv_prev;
  logic [2*DATA_W-1:0] exp_q[$];
  int                 n_checks;
  int                 n_pass;

  ex_div_unit #(.DATA_W(DATA_W), .STALL_W(STALL_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .div_start       (div_start),
    .div_signed      (div_signed),
    .dividend        (dividend),
    .divisor         (divisor),
    .stallreq_for_ex (stallreq_for_ex),
    .result_valid    (result_valid),
    .quotient        (quotient),
    .remainder       (remainder),
    .dbg_state       (dbg_state)
  );

  // Stall controller stand-in: answers a request with 001111, and can be
  // forced to hold the pipeline to model a downstream stall.
  assign stall = (stallreq_for_ex || hold_stall) ? 6'b001111 : 6'b000000;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Reference: truncating division; divide by zero gives all ones / dividend.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, uq, ur, q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    ua = (sgn && a[31]) ? (32'd0 - a) : a;
    ub = (sgn && b[31]) ? (32'd0 - b) : b;
    uq = ua / ub;
    ur = ua % ub;
    q  = (sgn && (a[31] ^ b[31])) ? (32'd0 - uq) : uq;
    r  = (sgn && a[31]) ? (32'd0 - ur) : ur;
    return {q, r};
  endfunction

  // Scoreboard: compare on the first cycle of each result.
  always @(negedge clk) begin
    if (!rst && result_valid && !rv_prev) begin
      check("sb_expected_present", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("sb_quotient", 64'(quotient), 64'(e[63:32]));
        check("sb_remainder", 64'(remainder), 64'(e[31:0]));
      end
    end
    rv_prev = rst ? 1'b0 : result_valid;
  end

  // Driver: issue one divide, hold div_start until the instruction leaves EX.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input int hold);
    int cyc;
    int req;
    logic [31:0] q0, r0;
    @(posedge clk); #1;
    exp_q.push_back({eq, er});
    div_signed = sgn;
    dividend   = a;
    divisor    = b;
    div_start  = 1'b1;
    hold_stall = (hold > 0);
    cyc = 0;
    req = 0;
    @(negedge clk);
    while (!result_valid && cyc < 100) begin
      if (stallreq_for_ex) req++;
      cyc++;
      @(negedge clk);
    end
    check("done_reached", 64'(result_valid), 64'd1);
    check("stallreq_cycles", 64'(req), (b == 32'd0) ? 64'd1 : 64'd33);
    check("latency", 64'(cyc), (b == 32'd0) ? 64'd1 : 64'd33);
    q0 = quotient;
    r0 = remainder;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clk);
      check("hold_valid", 64'(result_valid), 64'd1);
      check("hold_state", 64'(dbg_state), 64'(ST_DONE));
      check("hold_stallreq", 64'(stallreq_for_ex), 64'd0);
      check("hold_stable", {quotient, remainder}, {q0, r0});
    end
    hold_stall = 1'b0;
    @(posedge clk); #1;
    div_start = 1'b0;
    @(negedge clk);
    check("back_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("idle_valid", 64'(result_valid), 64'd0);
    check("idle_hold_out", {quotient, remainder}, {q0, r0});
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    logic [63:0] e;
    n_checks   = 0;
    n_pass     = 0;
    rv_prev    = 1'b0;
    rst        = 1'b1;
    hold_stall = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    dividend   = '0;
    divisor    = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_stallreq", 64'(stallreq_for_ex), 64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_outputs", {quotient, remainder}, 64'd0);

    // Directed cases
    do_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
    do_div(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0);
    do_div(1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 0);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);
    do_div(1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 0);
    do_div(1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 3);
    do_div(1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 0);

    // Reset at CALC step 10
    @(posedge clk); #1;
    div_signed = 1'b0;
    dividend   = 32'hDEAD_BEEF;
    divisor    = 32'd13;
    div_start  = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    check("pre_rst_calc", 64'(dbg_state), 64'(ST_CALC));
    rst = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    div_start = 1'b0;
    @(negedge clk);
    check("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("midrst_stallreq", 64'(stallreq_for_ex), 64'd0);
    check("midrst_valid", 64'(result_valid), 64'd0);
    check("midrst_outputs", {quotient, remainder}, 64'd0);
    do_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 0);

    // Random operands, checked against the reference
    for (int i = 0; i < 8; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(1, 20));
        1: b = 32'd0 - 32'($urandom_range(1, 20));
        2: b = $urandom;
        default: b = 32'd0;
      endcase
      e = ref_div(s, a, b);
      do_div(s, a, b, e[63:32], e[31:0], int'($urandom_range(0, 2)));
    end

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
